// File: rtl/if_id_stage_pkg.sv
// Shared MIPS decode constants and helpers for the IF/ID pipeline register.
package if_id_stage_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_BNE   = 6'h05;
    localparam logic [5:0]  OP_LW    = 6'h23;
    localparam logic [5:0]  OP_SW    = 6'h2B;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Opcodes that read rt as a source operand (not as a destination).
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// Combinational load-use hazard detect between the IF/ID slot and a load in ID/EX.
import if_id_stage_pkg::*;

module load_use_detect (
    input  logic       if_id_valid,
    input  logic [5:0] opcode,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rt,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (id_ex_rt == rs);
    assign rt_match = (id_ex_rt == rt) && uses_rt(opcode);

    // $zero is never a real dependency, and an empty slot reads nothing.
    assign hazard = id_ex_mem_read && if_id_valid && (id_ex_rt != 5'd0)
                    && (rs_match || rt_match);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: holds fetched instruction and pc+4, decodes fields,
// stalls on load-use, squashes on taken branch/jump, counts stalls and flushes.
import if_id_stage_pkg::*;

module if_id_stage #(
    parameter int PC_W   = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instruction,
    input  logic [PC_W-1:0]   pc_plus_4,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              id_ex_mem_read,
    input  logic [4:0]        id_ex_rt,
    output logic              pc_write,
    output logic              id_ex_bubble,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [PC_W-1:0]   if_id_pc_plus_4,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] imm_sext,
    output logic [25:0]       jump_target,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic hazard;
    logic flush;

    assign opcode      = if_id_instr[31:26];
    assign rs          = if_id_instr[25:21];
    assign rt          = if_id_instr[20:16];
    assign rd          = if_id_instr[15:11];
    assign shamt       = if_id_instr[10:6];
    assign funct       = if_id_instr[5:0];
    assign imm_sext    = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};
    assign jump_target = if_id_instr[25:0];

    load_use_detect u_load_use_detect (
        .if_id_valid    (if_id_valid),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .hazard         (hazard)
    );

    // A flush discards the stalled slot, so the stall is cancelled outright.
    assign flush        = branch_taken | jump;
    assign pc_write     = ~hazard | flush;
    assign id_ex_bubble = hazard & ~flush;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            if_id_instr     <= '0;
            if_id_pc_plus_4 <= '0;
            if_id_valid     <= 1'b0;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
        end else if (flush) begin
            if_id_instr     <= NOP_WORD[DATA_W-1:0];
            if_id_pc_plus_4 <= '0;
            if_id_valid     <= 1'b0;
            if (flush_cnt != {CNT_W{1'b1}}) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end else if (hazard) begin
            if (stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else begin
            if_id_instr     <= instruction;
            if_id_pc_plus_4 <= pc_plus_4;
            if_id_valid     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage with hand-computed expectations.
module tb_if_id_stage;

    logic        pclk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [9:0]  pc_plus_4;
    logic        branch_taken;
    logic        jump;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic        pc_write;
    logic        id_ex_bubble;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [9:0]  if_id_pc_plus_4;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [25:0] jump_target;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks   = 0;
    int failures = 0;

    if_id_stage dut (
        .pclk            (pclk),
        .reset           (reset),
        .instruction     (instruction),
        .pc_plus_4       (pc_plus_4),
        .branch_taken    (branch_taken),
        .jump            (jump),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rt        (id_ex_rt),
        .pc_write        (pc_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus_4 (if_id_pc_plus_4),
        .opcode          (opcode),
        .rs              (rs),
        .rt              (rt),
        .rd              (rd),
        .shamt           (shamt),
        .funct           (funct),
        .imm_sext        (imm_sext),
        .jump_target     (jump_target),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        instruction    = 32'h0;
        pc_plus_4      = 10'h0;
        branch_taken   = 1'b0;
        jump           = 1'b0;
        id_ex_mem_read = 1'b0;
        id_ex_rt       = 5'd0;
        tick();
        tick();
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_valid", if_id_valid, 1'b0);
        check("rst_pcw", pc_write, 1'b1);
        reset = 1'b0;

        // 1: reset mid-stall
        instruction = 32'h8C220004;
        pc_plus_4   = 10'h004;
        tick();
        check("t1_instr", if_id_instr, 32'h8C220004);
        check("t1_imm", imm_sext, 32'h4);
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd1;   // matches rs of lw $2,4($1)
        #1;
        check("t1_hazard_pcw", pc_write, 1'b0);
        tick();
        check("t1_stall_cnt", stall_cnt, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t1_rst_instr", if_id_instr, 32'h0);
        check("t1_rst_pc4", if_id_pc_plus_4, 10'h0);
        check("t1_rst_valid", if_id_valid, 1'b0);
        check("t1_rst_rs", rs, 5'd0);
        check("t1_rst_stall", stall_cnt, 16'd0);
        check("t1_rst_flush", flush_cnt, 16'd0);
        check("t1_rst_pcw", pc_write, 1'b1);
        check("t1_rst_bubble", id_ex_bubble, 1'b0);
        id_ex_mem_read = 1'b0;
        id_ex_rt       = 5'd0;
        @(negedge pclk);
        reset = 1'b0;

        // 2: plain flow
        instruction = 32'h00430820;
        pc_plus_4   = 10'h008;
        tick();
        check("t2_rs", rs, 5'd2);
        check("t2_rt", rt, 5'd3);
        check("t2_rd", rd, 5'd1);
        check("t2_funct", funct, 6'h20);
        check("t2_opcode", opcode, 6'h00);
        check("t2_valid", if_id_valid, 1'b1);
        check("t2_pc4", if_id_pc_plus_4, 10'h008);
        check("t2_pcw", pc_write, 1'b1);

        // 3: load-use on rt of R-type
        instruction    = 32'h12345678;
        pc_plus_4      = 10'h00C;
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd3;
        #1;
        check("t3_pcw", pc_write, 1'b0);
        check("t3_bubble", id_ex_bubble, 1'b1);
        tick();
        check("t3_held_instr", if_id_instr, 32'h00430820);
        check("t3_held_pc4", if_id_pc_plus_4, 10'h008);
        check("t3_stall_cnt", stall_cnt, 16'd1);
        id_ex_mem_read = 1'b0;
        #1;
        check("t3_released", pc_write, 1'b1);

        // 4: addi does not read rt; rs still does
        instruction = 32'h20410005;
        pc_plus_4   = 10'h010;
        tick();
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd1;
        #1;
        check("t4_addi_rt_pcw", pc_write, 1'b1);
        check("t4_addi_rt_bub", id_ex_bubble, 1'b0);
        id_ex_rt = 5'd2;
        #1;
        check("t4_addi_rs_pcw", pc_write, 1'b0);
        id_ex_mem_read = 1'b0;
        instruction    = 32'h00000820;   // add $1,$0,$0
        tick();
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd0;
        #1;
        check("t4_zero_pcw", pc_write, 1'b1);
        tick();
        check("t4_stall_cnt", stall_cnt, 16'd1);

        // 5: flush beats stall
        id_ex_mem_read = 1'b0;
        instruction    = 32'h00430820;
        pc_plus_4      = 10'h014;
        tick();
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd3;
        branch_taken   = 1'b1;
        #1;
        check("t5_pcw", pc_write, 1'b1);
        check("t5_bubble", id_ex_bubble, 1'b0);
        tick();
        check("t5_instr", if_id_instr, 32'h0);
        check("t5_valid", if_id_valid, 1'b0);
        check("t5_pc4", if_id_pc_plus_4, 10'h0);
        check("t5_flush_cnt", flush_cnt, 16'd1);
        check("t5_stall_cnt", stall_cnt, 16'd1);
        branch_taken = 1'b0;
        #1;
        // NOP slot: rs=rt=0 and id_ex_rt=3, but also valid=0 must mask any match
        check("t5_nop_pcw", pc_write, 1'b1);
        id_ex_mem_read = 1'b0;

        // 6: flush counter saturation
        jump = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            @(posedge pclk);
        end
        #1;
        check("t6_sat", flush_cnt, 16'hFFFF);
        tick();
        tick();
        check("t6_sat_hold", flush_cnt, 16'hFFFF);
        jump        = 1'b0;
        instruction = 32'h2001FFFF;
        tick();
        check("t6_imm_sext", imm_sext, 32'hFFFFFFFF);
        check("t6_jtarget", jump_target, 26'h001FFFF);
        check("t6_flush_after", flush_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
